// File: rtl/bus_pkg.sv
// Shared types and constants for the peripheral bus initiator.
package bus_pkg;

  localparam int BUS_W  = 16;
  localparam int ADDR_W = 32;

  // Driven while idle; no peripheral decodes this address.
  localparam logic [ADDR_W-1:0] IDLE_ADDR_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/bus_master_ctrl_if.sv
// Core-side request/response and bus-side strobes of the bus initiator.
interface bus_master_ctrl_if;
  import bus_pkg::*;

  // Handshake: the core raises req (with we/addr/wdata stable) and holds it
  // until the controller leaves IDLE; completion is a one-cycle ack, with err
  // alongside it for a timed-out read. rdata is valid while ack is high.
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BUS_W-1:0]  wdata;
  logic [BUS_W-1:0]  rdata;
  logic              ack;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] address;
  logic              writeEn;
  logic              outputEn;

  modport master (
    input  req, we, addr, wdata,
    output rdata, ack, err, busy, address, writeEn, outputEn
  );

  modport slave (
    output req, we, addr, wdata,
    input  rdata, ack, err, busy, address, writeEn, outputEn
  );

endinterface

// File: rtl/triState.sv
// Tristate driver: passes data onto y while en is high, otherwise releases it.
module triState #(
  parameter int W = 16
) (
  input  logic [W-1:0] data,
  input  logic         en,
  output wire  [W-1:0] y
);

  assign y = en ? data : {W{1'bz}};

endmodule

// File: rtl/bus_master_ctrl.sv
// Single-transaction initiator for the shared 16-bit memory-mapped bus.
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int                TIMEOUT   = 16,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = IDLE_ADDR_DEFAULT
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  bus_master_ctrl_if.master  bif,
  inout  wire  [BUS_W-1:0]   BUS,
  input  logic               readDone,
  output state_e             dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_W-1:0]  wdata_q, wdata_d;
  logic [BUS_W-1:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              wen_q, wen_d;
  logic              oen_q, oen_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              drive_en;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bif.req) begin
          addr_d  = bif.addr;
          wdata_d = bif.wdata;
          state_d = bif.we ? WRITE : READ;
        end
      end
      WRITE: state_d = RESP;
      READ: begin
        // A completing responder takes priority over an expiring timeout.
        if (readDone == 1'b1) begin
          rdata_d = BUS;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered.
    busy_d    = (state_d != IDLE);
    wen_d     = (state_d == WRITE);
    oen_d     = (state_d == READ);
    ack_d     = (state_d == RESP);
    address_d = (wen_d || oen_d) ? addr_d : IDLE_ADDR;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      wen_q     <= 1'b0;
      oen_q     <= 1'b0;
      address_q <= IDLE_ADDR;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      wen_q     <= wen_d;
      oen_q     <= oen_d;
      address_q <= address_d;
    end
  end

  assign drive_en = (state_q == WRITE);

  triState #(.W(BUS_W)) u_tri (
    .data (wdata_q),
    .en   (drive_en),
    .y    (BUS)
  );

  assign bif.rdata    = rdata_q;
  assign bif.ack      = ack_q;
  assign bif.err      = err_q;
  assign bif.busy     = busy_q;
  assign bif.address  = address_q;
  assign bif.writeEn  = wen_q;
  assign bif.outputEn = oen_q;
  assign dbg_state_o  = state_q;

endmodule
